// File: rtl/bus_drive_arbiter_pkg.sv
// rtl/bus_drive_arbiter_pkg.sv - shared constants and state encoding for the CPU bus drive arbiter
package bus_drive_arbiter_pkg;

  localparam int BUS_W        = 18;
  localparam int TURN_DEFAULT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bus_drive_arbiter_if.sv
// rtl/bus_drive_arbiter_if.sv - request/grant/enable bundle between requesters and the arbiter
interface bus_drive_arbiter_if #(
  parameter int N_REQ = 4
) ();

  logic [N_REQ-1:0]         req;
  logic [N_REQ-1:0]         grant;
  logic [N_REQ-1:0]         drive_en;
  logic [$clog2(N_REQ)-1:0] owner_id;
  logic                     bus_busy;
  logic                     timeout;

  modport master (
    input  req,
    output grant,
    output drive_en,
    output owner_id,
    output bus_busy,
    output timeout
  );

  modport slave (
    output req,
    input  grant,
    input  drive_en,
    input  owner_id,
    input  bus_busy,
    input  timeout
  );

endinterface

// File: rtl/bus_drive_arbiter_rr_pick.sv
// rtl/bus_drive_arbiter_rr_pick.sv - combinational round-robin picker
// Rotates req so rr_ptr lands on bit 0, takes the lowest set bit, then rotates the index back.
module bus_drive_arbiter_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    rr_ptr_i,
  output logic             valid_o,
  output logic [IW-1:0]    idx_o,
  output logic [N_REQ-1:0] onehot_o
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IW-1:0]      enc;
  logic [IW:0]        sum;

  assign dbl = {req_i, req_i} >> rr_ptr_i;
  assign rot = dbl[N_REQ-1:0];

  always_comb begin
    valid_o  = 1'b0;
    enc      = '0;
    sum      = '0;
    idx_o    = '0;
    onehot_o = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid_o = 1'b1;
        enc     = IW'(i);
      end
    end
    // Un-rotate: add the pointer back, modulo N_REQ (N_REQ need not be a power of two).
    sum = {1'b0, rr_ptr_i} + {1'b0, enc};
    if (sum >= (IW+1)'(N_REQ)) begin
      sum = sum - (IW+1)'(N_REQ);
    end
    idx_o = sum[IW-1:0];
    if (valid_o) begin
      onehot_o = N_REQ'(1) << idx_o;
    end
  end

endmodule

// File: rtl/bus_drive_arbiter.sv
// rtl/bus_drive_arbiter.sv - round-robin owner FSM with turnaround gap for the shared tristate data bus
// Enables are driven straight from the grant flops so the buffers never see decode glitches.
module bus_drive_arbiter
  import bus_drive_arbiter_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int MAX_HOLD    = 8,
  parameter int TURN_CYCLES = TURN_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  bus_drive_arbiter_if.master bus
);

  localparam int IW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD);
  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [TW-1:0]    turn_cnt_q, turn_cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic             timeout_q, timeout_d;

  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic [N_REQ-1:0] pick_onehot;
  logic             owner_req;

  bus_drive_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req_i    (bus.req),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot)
  );

  assign owner_req = bus.req[owner_q];

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    turn_cnt_d = turn_cnt_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d    = pick_onehot;
          owner_d    = pick_idx;
          hold_cnt_d = '0;
          state_d    = ST_OWN;
        end
      end
      ST_OWN: begin
        if (!owner_req || (hold_cnt_q == HW'(MAX_HOLD - 1))) begin
          // Only a cut-off of a still-requesting owner is a timeout.
          timeout_d  = owner_req;
          grant_d    = '0;
          owner_d    = '0;
          rr_ptr_d   = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);
          turn_cnt_d = '0;
          state_d    = ST_TURN;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      ST_TURN: begin
        if (turn_cnt_q == TW'(TURN_CYCLES - 1)) begin
          if (pick_valid) begin
            grant_d    = pick_onehot;
            owner_d    = pick_idx;
            hold_cnt_d = '0;
            state_d    = ST_OWN;
          end else begin
            state_d    = ST_IDLE;
          end
        end else begin
          turn_cnt_d = turn_cnt_q + TW'(1);
        end
      end
      default: begin
        grant_d = '0;
        owner_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      turn_cnt_q <= '0;
      grant_q    <= '0;
      owner_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.drive_en = grant_q;
  assign bus.owner_id = owner_q;
  assign bus.bus_busy = |grant_q;
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_bus_drive_arbiter.sv
// tb/tb_bus_drive_arbiter.sv - directed and random-traffic bench for bus_drive_arbiter
module tb_bus_drive_arbiter;
  import bus_drive_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  bus_drive_arbiter_if #(.N_REQ(4)) bus_if ();

  bus_drive_arbiter #(
    .N_REQ       (4),
    .MAX_HOLD    (8),
    .TURN_CYCLES (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] req_v;
    logic [3:0] prev_g;
    int         zeros;
    logic       seen;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus_if.req = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_grant", 32'(bus_if.grant), 32'h0);
    chk("rst_drive_en", 32'(bus_if.drive_en), 32'h0);
    chk("rst_owner", 32'(bus_if.owner_id), 32'h0);
    chk("rst_busy", 32'(bus_if.bus_busy), 32'h0);
    chk("rst_timeout", 32'(bus_if.timeout), 32'h0);

    // T2: single requester 1, held for cycles 0..2, dropped in cycle 3
    bus_if.req = 4'b0010;
    tick();
    chk("t2_c1_grant", 32'(bus_if.grant), 32'h2);
    chk("t2_c1_drive_en", 32'(bus_if.drive_en), 32'h2);
    chk("t2_c1_owner", 32'(bus_if.owner_id), 32'h1);
    chk("t2_c1_busy", 32'(bus_if.bus_busy), 32'h1);
    tick();
    chk("t2_c2_grant", 32'(bus_if.grant), 32'h2);
    tick();
    chk("t2_c3_grant", 32'(bus_if.grant), 32'h2);
    bus_if.req = 4'b0000;
    tick();
    chk("t2_c4_grant", 32'(bus_if.grant), 32'h0);
    chk("t2_c4_timeout", 32'(bus_if.timeout), 32'h0);
    chk("t2_c4_state", 32'(dut.state_q), 32'(ST_TURN));
    tick();
    chk("t2_c5_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("t2_c5_busy", 32'(bus_if.bus_busy), 32'h0);

    // T1: rr_ptr is now 2, so req[2] wins; reset asynchronously mid-ownership
    bus_if.req = 4'b0100;
    tick();
    chk("t1_grant", 32'(bus_if.grant), 32'h4);
    chk("t1_owner", 32'(bus_if.owner_id), 32'h2);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("t1_rst_grant", 32'(bus_if.grant), 32'h0);
    chk("t1_rst_drive_en", 32'(bus_if.drive_en), 32'h0);
    chk("t1_rst_timeout", 32'(bus_if.timeout), 32'h0);
    chk("t1_rst_busy", 32'(bus_if.bus_busy), 32'h0);
    chk("t1_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("t1_rst_ptr", 32'(dut.rr_ptr_q), 32'h0);
    bus_if.req = 4'b0000;
    tick();
    reset = 1'b0;
    tick();

    // T3: all request; each owner drops after 2 cycles and re-requests during the gap
    bus_if.req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      int k;
      k = i % 4;
      chk($sformatf("t3_own%0d_grant_a", i), 32'(bus_if.grant), 32'(1) << k);
      chk($sformatf("t3_own%0d_owner", i), 32'(bus_if.owner_id), 32'(k));
      tick();
      chk($sformatf("t3_own%0d_grant_b", i), 32'(bus_if.grant), 32'(1) << k);
      bus_if.req[k] = 1'b0;
      tick();
      chk($sformatf("t3_own%0d_gap", i), 32'(bus_if.grant), 32'h0);
      bus_if.req[k] = 1'b1;
      tick();
    end
    chk("t3_next_grant", 32'(bus_if.grant), 32'h2);
    bus_if.req = 4'b0000;
    tick();
    tick();
    chk("t3_drain_state", 32'(dut.state_q), 32'(ST_IDLE));

    // T4: sole requester 0 held; cut off after exactly 8 cycles, then re-granted
    bus_if.req = 4'b0001;
    tick();
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("t4_c%0d_grant", c), 32'(bus_if.grant), 32'h1);
      chk($sformatf("t4_c%0d_timeout", c), 32'(bus_if.timeout), 32'h0);
      tick();
    end
    chk("t4_cut_grant", 32'(bus_if.grant), 32'h0);
    chk("t4_cut_timeout", 32'(bus_if.timeout), 32'h1);
    tick();
    chk("t4_regrant", 32'(bus_if.grant), 32'h1);
    chk("t4_pulse_end", 32'(bus_if.timeout), 32'h0);

    // T5: req drops on the same edge the hold limit is reached
    for (int c = 11; c <= 17; c++) begin
      tick();
      chk($sformatf("t5_c%0d_grant", c), 32'(bus_if.grant), 32'h1);
    end
    bus_if.req = 4'b0000;
    tick();
    chk("t5_rel_grant", 32'(bus_if.grant), 32'h0);
    chk("t5_rel_timeout", 32'(bus_if.timeout), 32'h0);
    tick();
    chk("t5_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // T6: random traffic, invariants every cycle
    req_v  = 4'b0000;
    prev_g = 4'b0000;
    zeros  = 0;
    seen   = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_v = 4'($urandom);
      end
      bus_if.req = req_v;
      tick();
      chk("t6_onehot0", 32'($onehot0(bus_if.drive_en)), 32'h1);
      chk("t6_en_eq_grant", 32'(bus_if.drive_en), 32'(bus_if.grant));
      chk("t6_busy", 32'(bus_if.bus_busy), 32'(|bus_if.grant));
      if (bus_if.grant != 4'b0000) begin
        if (prev_g != 4'b0000) begin
          chk("t6_no_direct_handover", 32'(bus_if.grant), 32'(prev_g));
        end else if (seen) begin
          chk("t6_turn_gap", 32'(zeros >= 1), 32'h1);
        end
        seen  = 1'b1;
        zeros = 0;
      end else begin
        zeros++;
      end
      prev_g = bus_if.grant;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
